// File: rtl/gate_ctrl_param.sv
// Parking-gate access controller: PIN check against a programmable stored PIN, saturating
// failed-attempt counter, tailgate lockout and open-too-long alarm; Moore outputs, 1-cycle latency.
module gate_ctrl_param #(
    parameter int               PIN_W        = 8,
    parameter logic [PIN_W-1:0] PIN_DEFAULT  = 8'h08,
    parameter int               MAX_TRIES    = 3,
    parameter int               OPEN_TIMEOUT = 16,
    localparam int              TRY_W        = $clog2(MAX_TRIES + 1),
    localparam int              TMR_W        = $clog2(OPEN_TIMEOUT + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Vehiculo,
    input  logic             Termino,
    input  logic             enterPin,
    input  logic [PIN_W-1:0] Pin,
    input  logic             ProgEn,
    input  logic [PIN_W-1:0] NewPin,
    output logic             Cerrado,
    output logic             Abierto,
    output logic             Alarma,
    output logic             Bloqueo,
    output logic [TRY_W-1:0] Intentos
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'b00,
        ST_OPEN    = 2'b01,
        ST_BLOCKED = 2'b10
    } state_t;

    localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(OPEN_TIMEOUT);

    state_t             r_state;
    logic [TRY_W-1:0]   r_tries;
    logic [TMR_W-1:0]   r_timer;
    logic [PIN_W-1:0]   r_pin;
    logic               r_cerrado;
    logic               r_abierto;
    logic               r_alarma;
    logic               r_bloqueo;

    state_t             w_state_nxt;
    logic [TRY_W-1:0]   w_tries_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [PIN_W-1:0]   w_pin_nxt;
    logic               w_match;
    logic               w_alarma_nxt;

    assign w_match = (Pin == r_pin);

    always_comb begin
        w_state_nxt = r_state;
        w_tries_nxt = r_tries;
        w_timer_nxt = r_timer;
        w_pin_nxt   = r_pin;
        case (r_state)
            ST_CLOSED: begin
                if (enterPin) begin
                    if (ProgEn && w_match && !Vehiculo) begin
                        w_pin_nxt   = NewPin;
                        w_tries_nxt = '0;
                    end else if (!w_match && (ProgEn || Vehiculo)) begin
                        if (r_tries != TRIES_MAX)
                            w_tries_nxt = r_tries + 1'b1;
                    end else if (Vehiculo && w_match && !ProgEn) begin
                        w_state_nxt = ST_OPEN;
                        w_timer_nxt = '0;
                        w_tries_nxt = '0;
                    end
                end
            end
            ST_OPEN: begin
                // Attempts are cleared on the entering edge, so tries stays zero throughout OPEN.
                w_tries_nxt = '0;
                if (Termino) begin
                    w_state_nxt = Vehiculo ? ST_BLOCKED : ST_CLOSED;
                end else if (r_timer != TMR_MAX) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_BLOCKED: begin
                if (enterPin && w_match) begin
                    w_state_nxt = ST_OPEN;
                    w_timer_nxt = '0;
                    w_tries_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLOSED;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_alarma_nxt = 1'b0;
        case (w_state_nxt)
            ST_CLOSED:  w_alarma_nxt = (w_tries_nxt == TRIES_MAX);
            ST_OPEN:    w_alarma_nxt = (w_timer_nxt == TMR_MAX);
            ST_BLOCKED: w_alarma_nxt = 1'b1;
            default:    w_alarma_nxt = 1'b0;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_CLOSED;
            r_tries   <= '0;
            r_timer   <= '0;
            r_pin     <= PIN_DEFAULT;
            r_cerrado <= 1'b1;
            r_abierto <= 1'b0;
            r_alarma  <= 1'b0;
            r_bloqueo <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tries   <= w_tries_nxt;
            r_timer   <= w_timer_nxt;
            r_pin     <= w_pin_nxt;
            r_cerrado <= (w_state_nxt == ST_CLOSED);
            r_abierto <= (w_state_nxt == ST_OPEN);
            r_alarma  <= w_alarma_nxt;
            r_bloqueo <= (w_state_nxt == ST_BLOCKED);
        end
    end

    assign Cerrado  = r_cerrado;
    assign Abierto  = r_abierto;
    assign Alarma   = r_alarma;
    assign Bloqueo  = r_bloqueo;
    assign Intentos = r_tries;

endmodule
